data_mem_bridge: RTL

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge_if.sv | 37 +++
 rtl/data_mem_bridge.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge_if.sv
// CPU-side and memory-side channels of the data memory bridge.
// The master modport is the bridge's view; slave is the CPU/memory environment's view.
interface data_mem_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  cpu_req_i;
    logic [BE_WIDTH-1:0]   cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  cpu_stall_o;

    logic                  mem_req_o;
    logic [BE_WIDTH-1:0]   mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ready_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/data_mem_bridge.sv
// MEM-stage to data-memory bridge: latches one load/store, stalls the pipeline until it completes.
// Optional watchdog enabled by defining DATA_MEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    data_mem_bridge_if.master      bus,
    output logic                   err_o,
    output logic [31:0]            stall_cnt_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BE_WIDTH-1:0]   r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [31:0]           r_stall_cnt;

    logic w_is_load;
    logic w_busy;
    logic w_complete;
    logic w_timeout;
    logic w_abort;
    logic w_stall;

    assign w_is_load  = (r_we == '0);
    assign w_busy     = (r_state == REQ) || (r_state == WAIT_R);
    assign w_complete = ((r_state == REQ) && bus.mem_ready_i) ||
                        ((r_state == WAIT_R) && bus.mem_rvalid_i);

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;
    logic        r_err;

    // Watchdog fires on the cycle that would make the busy-cycle count reach the limit.
    assign w_timeout = w_busy && (r_wdog == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if ((r_state == IDLE) && bus.cpu_req_i) begin
            r_wdog <= '0;
        end else if (w_busy) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // A genuine completion on the same cycle as the watchdog limit wins.
    assign w_abort = w_timeout && !w_complete;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ready_i) begin
                    w_state_next = w_is_load ? WAIT_R : DONE;
                end else if (w_abort) begin
                    w_state_next = DONE;
                end
            end
            WAIT_R: begin
                if (bus.mem_rvalid_i || w_abort) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && bus.cpu_req_i) begin
                r_addr  <= bus.cpu_addr_i;
                r_we    <= bus.cpu_we_i;
                r_wdata <= bus.cpu_wdata_i;
            end
            if ((r_state == WAIT_R) && bus.mem_rvalid_i) begin
                r_rdata <= bus.mem_rdata_i;
            end else if (w_abort && w_is_load) begin
                r_rdata <= '1;
            end
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = bus.cpu_req_i;
            REQ:     w_stall = 1'b1;
            WAIT_R:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.cpu_stall_o = w_stall;
    assign bus.cpu_rdata_o = r_rdata;
    assign bus.mem_req_o   = (r_state == REQ);
    assign bus.mem_we_o    = r_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign stall_cnt_o     = r_stall_cnt;
endmodule
